// File: rtl/seg_display_driver_if.sv
// Bus between the value/format source and the multiplexed 7-segment driver.
// The master supplies the word and format; the slave drives the display pins.
interface seg_display_driver_if #(
    parameter int WORD_W = 16,
    parameter int DIGITS = WORD_W / 4
);
    logic [WORD_W-1:0] digits;
    logic              blank_en;
    logic [DIGITS-1:0] dp_sel;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;
    logic              frame_done;

    modport master (
        output digits, blank_en, dp_sel,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  digits, blank_en, dp_sel,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg_display_driver.sv
// Time-multiplexed 7-segment driver. The word is latched once per frame, so a
// frame never mixes two values. Optional leading-zero blanking is supported.
module seg_display_driver #(
    parameter int WORD_W      = 16,
    parameter int DIGITS      = WORD_W / 4,
    parameter int REFRESH_CNT = 50000
) (
    input  logic               clk,
    input  logic               reset,
    seg_display_driver_if.slave bus
);
    localparam int PRE_W  = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam int SCAN_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(REFRESH_CNT - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGITS - 1);

    logic [PRE_W-1:0]    pre_reg;
    logic [SCAN_W-1:0]   scan_reg;
    logic [4*DIGITS-1:0] sh_digits_reg;
    logic                sh_blank_reg;
    logic [DIGITS-1:0]   sh_dp_reg;
    logic                frame_done_reg;
    logic [6:0]          seg_reg;
    logic                dp_reg;
    logic [DIGITS-1:0]   an_reg;

    logic                tick;
    logic                frame_end;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   an_base;
    logic [DIGITS-1:0]   blanked;
    logic [6:0]          seg_next;
    logic                dp_next;
    logic [DIGITS-1:0]   an_next;

    assign tick      = (pre_reg == PRE_LAST);
    assign frame_end = tick && (scan_reg == SCAN_LAST);

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        // active-high gfedcba
        case (v)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]     = sh_digits_reg[gi*4 +: 4];
            assign an_base[gi] = (scan_reg != SCAN_W'(gi));
        end
    endgenerate

    // Walk down from the most significant digit; a digit is blanked while
    // everything at and above it is zero. Digit 0 is always shown.
    always_comb begin
        logic all_zero;
        blanked  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero   = all_zero && (nib[i] == 4'd0);
            blanked[i] = sh_blank_reg && all_zero;
        end
    end

    always_comb begin
        seg_next = ~hex_to_seg(nib[scan_reg]);
        dp_next  = ~sh_dp_reg[scan_reg];
        an_next  = an_base;
        if (blanked[scan_reg]) begin
            seg_next = 7'h7F;
            dp_next  = 1'b1;
            an_next  = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_reg        <= '0;
            scan_reg       <= '0;
            sh_digits_reg  <= '0;
            sh_blank_reg   <= 1'b0;
            sh_dp_reg      <= '0;
            frame_done_reg <= 1'b0;
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            an_reg         <= '1;
        end else begin
            pre_reg <= tick ? '0 : pre_reg + 1'b1;
            if (tick) begin
                scan_reg <= (scan_reg == SCAN_LAST) ? '0 : scan_reg + 1'b1;
            end
            if (frame_end) begin
                sh_digits_reg <= bus.digits[4*DIGITS-1:0];
                sh_blank_reg  <= bus.blank_en;
                sh_dp_reg     <= bus.dp_sel;
            end
            frame_done_reg <= frame_end;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
        end
    end

    assign bus.seg        = seg_reg;
    assign bus.dp         = dp_reg;
    assign bus.an         = an_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seg_display_driver.sv
// Directed and randomized checks of the 7-segment driver against a
// time-based model: edge n after reset shows slot ((n-1)/R)%D of the last captured word.
module tb_seg_display_driver;
    localparam int WORD_W = 16;
    localparam int DIGITS = 4;
    localparam int R      = 4;
    localparam int FRAME  = R * DIGITS;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic reset;

    seg_display_driver_if #(.WORD_W(WORD_W), .DIGITS(DIGITS)) bus ();

    seg_display_driver #(
        .WORD_W(WORD_W), .DIGITS(DIGITS), .REFRESH_CNT(R)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int n          = 0;      // rising edges since reset release
    int frames     = 0;
    logic [15:0] m_digits = '0;
    logic        m_blank  = 1'b0;
    logic [3:0]  m_dp     = '0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic b, input logic [3:0] p);
        bus.digits   = d;
        bus.blank_en = b;
        bus.dp_sel   = p;
    endtask

    // One clock: predict from the model, advance the model, check outputs.
    task automatic step();
        int s;
        logic [3:0] nibv;
        logic       blk;
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        logic       exp_dp;
        logic       exp_fd;
        @(posedge clk);
        n++;
        s    = ((n - 1) / R) % DIGITS;
        nibv = 4'(m_digits >> (4 * s));
        blk  = m_blank && (s > 0) && ((m_digits >> (4 * s)) == 16'd0);
        if (blk) begin
            exp_seg = 7'h7F;
            exp_an  = 4'hF;
            exp_dp  = 1'b1;
        end else begin
            exp_seg   = ~HEX_TAB[nibv];
            exp_an    = 4'hF;
            exp_an[s] = 1'b0;
            exp_dp    = ~m_dp[s];
        end
        exp_fd = ((n % FRAME) == 0);
        if ((n % FRAME) == 0) begin
            m_digits = bus.digits;
            m_blank  = bus.blank_en;
            m_dp     = bus.dp_sel;
            frames++;
            $display("frame %0d captured digits=%h blank=%b dp_sel=%b", frames, m_digits, m_blank, m_dp);
        end
        #1;
        check("seg", 16'(bus.seg), 16'(exp_seg));
        check("an", 16'(bus.an), 16'(exp_an));
        check("dp", 16'(bus.dp), 16'(exp_dp));
        check("frame_done", 16'(bus.frame_done), 16'(exp_fd));
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Asynchronous reset between edges; outputs must idle before the next edge.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_seg", 16'(bus.seg), 16'h7F);
        check("rst_an", 16'(bus.an), 16'hF);
        check("rst_dp", 16'(bus.dp), 16'h1);
        check("rst_fd", 16'(bus.frame_done), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        n        = 0;
        m_digits = '0;
        m_blank  = 1'b0;
        m_dp     = '0;
        $display("reset pulse applied");
    endtask

    task automatic check_slots(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] lit [4];
        lit = '{s0, s1, s2, s3};
        for (int k = 0; k < DIGITS; k++) begin
            step();
            check(tag, 16'(bus.seg), 16'(lit[k]));
            run(R - 1);
        end
    endtask

    initial begin
        logic [15:0] rd;
        reset = 1'b1;
        set_inputs(16'h0000, 1'b0, 4'b0000);
        @(posedge clk);
        #1;
        check("init_seg", 16'(bus.seg), 16'h7F);
        check("init_an", 16'(bus.an), 16'hF);
        check("init_dp", 16'(bus.dp), 16'h1);
        check("init_fd", 16'(bus.frame_done), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // Decode: first frame shows the reset shadow, second shows 1234.
        set_inputs(16'h1234, 1'b0, 4'b0000);
        step();
        check("first_an", 16'(bus.an), 16'hE);
        check("first_seg", 16'(bus.seg), 16'h40);
        run(FRAME - 1);
        check_slots("decode_1234", 7'h19, 7'h30, 7'h24, 7'h79);

        // Mid-frame change lands only in the following frame.
        run(R + 2);
        set_inputs(16'hABCD, 1'b0, 4'b0000);
        run(FRAME - R - 2);
        check_slots("decode_abcd", 7'h21, 7'h46, 7'h03, 7'h08);

        // Leading-zero blanking.
        set_inputs(16'h0005, 1'b1, 4'b0000);
        run(2 * FRAME);
        set_inputs(16'h0000, 1'b1, 4'b0000);
        run(2 * FRAME);
        set_inputs(16'h0300, 1'b1, 4'b1111);
        run(2 * FRAME);

        // Decimal point on digit 2 only.
        set_inputs(16'h1234, 1'b0, 4'b0100);
        run(2 * FRAME);

        // Reset during digit 2's slot, then restart from digit 0.
        run(2 * R + 2);
        mid_reset();
        step();
        check("post_rst_an", 16'(bus.an), 16'hE);
        check("post_rst_seg", 16'(bus.seg), 16'h40);
        run(2 * FRAME - 1);

        // Random words with random leading zeros, changed at random points.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rd = 16'($urandom);
                rd = rd >> (4 * $urandom_range(0, 4));
                set_inputs(rd, 1'($urandom_range(0, 1)), 4'($urandom));
            end
            if ($urandom_range(0, 249) == 0) mid_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Parameters
REQ-001 The block SHALL have parameter WORD_W, default 16: width of the displayed word, four bits per digit.
REQ-002 The block SHALL have parameter DIGITS, default WORD_W/4: number of multiplexed 7-segment digits.
REQ-003 The block SHALL have parameter REFRESH_CNT, default 50000 (legal values >= 2): clocks per digit slot.

Interface
REQ-004 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have input reset, 1 bit: asynchronous, active-high.
REQ-006 The block SHALL have input digits, WORD_W bits: value from the output register; nibble i drives digit i, digit 0 rightmost.
REQ-007 The block SHALL have input blank_en, 1 bit: 1 = leading-zero blanking on.
REQ-008 The block SHALL have input dp_sel, DIGITS bits: bit i = 1 lights the decimal point of digit i.
REQ-009 The block SHALL have output seg, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have output dp, 1 bit: decimal point, active-low.
REQ-011 The block SHALL have output an, DIGITS bits: digit anodes, active-low, at most one bit low.
REQ-012 The block SHALL have output frame_done, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_CNT-1, wrap to 0, and assert the internal tick while at REFRESH_CNT-1.
REQ-014 The scan index SHALL advance by one on tick and wrap from DIGITS-1 to 0.
REQ-015 On tick with scan index = DIGITS-1, the block SHALL capture digits, blank_en and dp_sel into shadow registers on that same edge.
REQ-016 The displayed value SHALL come only from the shadow registers; input changes mid-frame SHALL NOT appear until the next frame.
REQ-017 frame_done SHALL be high for exactly the one cycle following each shadow-capture edge.
REQ-018 seg, dp and an SHALL be registered and SHALL reflect the current scan index one clock after it changes (latency 1).
REQ-019 Active-high patterns (gfedcba), hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; seg SHALL be the bitwise inverse.
REQ-020 an SHALL be low only at the bit equal to the scan index.
REQ-021 dp SHALL be low only in digit i's slot when shadow dp_sel[i] = 1.
REQ-022 With shadow blank_en = 1, digit i (i > 0) SHALL be blanked when shadow nibbles i..DIGITS-1 are all zero.
REQ-023 When a digit is blanked, an SHALL be all ones and seg SHALL be 7'h7F for that slot; dp SHALL still follow REQ-021 only if the digit is not blanked.
REQ-024 Digit 0 SHALL never be blanked.

Reset
REQ-025 While reset is high, the prescaler, scan index and all shadow registers SHALL be 0, an SHALL be all ones, seg SHALL be 7'h7F, dp SHALL be 1 and frame_done SHALL be 0, immediately and independent of clk.
REQ-026 Reset asserted mid-slot or mid-frame SHALL abort the frame; after release, scanning SHALL restart at digit 0 with prescaler 0.
REQ-027 The first frame after reset SHALL display the shadow reset value 0 (blanking off); the input value SHALL appear from the second frame.

Verification (REFRESH_CNT = 4, DIGITS = 4)
REQ-028 Reset: assert reset during digit 2's slot -> an=1111, seg=7F, dp=1, frame_done=0 before the next clk edge; after release, the first edge gives an=1110, seg=40.
REQ-029 Decode: digits=16'h1234 held for two frames -> second frame shows an=1110/seg=19, 1101/30, 1011/24, 0111/79, each for 4 cycles.
REQ-030 Mid-frame change: digits 16'h1234 -> 16'hABCD during digit 1's slot -> digits 2 and 3 still show 2 and 1; the next frame shows d,C,b,A (seg=21,46,03,08).
REQ-031 Blanking: blank_en=1, digits=16'h0005 -> only digit 0 lit (seg=12), an=1111 in slots 1-3; digits=16'h0000 -> digit 0 shows seg=40.
REQ-032 frame_done is a single-cycle pulse every 16 cycles; dp_sel=4'b0100 gives dp=0 only while an=1011.
